regfile_writeback: RTL

//   Writer side of the MIPS register-file write port. Accepts results from EX/MEM

---
 rtl/regfile_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 91 +++++++++
 rtl/regfile_writeback.sv | 138 +++++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and the write-back entry type for the register-file writer.
// No logic, no latency.
// No backpressure; types only.
package regfile_pkg;

   localparam int ADDR_W = 5;
   localparam int DATA_W = 32;

   // $zero: writes to it are swallowed and probes of it never hit
   localparam logic [ADDR_W-1:0] REG_ZERO = '0;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data;
   } wb_entry_t;

   function automatic logic is_zero_reg(input logic [ADDR_W-1:0] a);
      return a == REG_ZERO;
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order queue of pending register writes, contents exported oldest-first for bypass search.
// Push visible in count/entries the cycle after the edge; head is combinational from storage.
// Push ignored when full, pop ignored when empty; flush empties the queue and wins over push/pop.
module wb_fifo
   import regfile_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  wb_entry_t        wr_entry,
   output wb_entry_t        head,
   output logic             full,
   output logic             empty,
   output logic [CNT_W-1:0] count,
   output wb_entry_t        ent     [DEPTH],
   output logic [DEPTH-1:0] ent_vld
);

   localparam int PTR_W = $clog2(DEPTH);

   wb_entry_t        mem_q [DEPTH];
   wb_entry_t        mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign head    = mem_q[rd_ptr_q];
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Next-state: pointers wrap naturally since DEPTH is a power of two
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         // push slot is the tail before any same-edge pop
         if (do_push) begin
            mem_d[wr_ptr_q] = wr_entry;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (!do_push && do_pop) begin
            count_d = count_q - CNT_W'(1);
         end
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Age-ordered view: ent[0] is the head, higher index is younger
   always_comb begin
      for (int i = 0; i < DEPTH; i++) begin
         ent[i]     = mem_q[rd_ptr_q + PTR_W'(i)];
         ent_vld[i] = (CNT_W'(i) < count_q);
      end
   end

endmodule

// File: rtl/regfile_writeback.sv
// Buffers EX/MEM results and drives the regfile write port, one write per cycle, yielding to reads.
// Accepted at edge N, on RegWrite/A3/WD3 from edge N+1, committed by the regfile at N+2.
// res_ready = !full from current occupancy; rd_req or flush stalls the drain for the next cycle.
module regfile_writeback #(
   parameter int DEPTH  = 2,
   parameter int ADDR_W = regfile_pkg::ADDR_W,
   parameter int DATA_W = regfile_pkg::DATA_W
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         res_valid,
   output logic                         res_ready,
   input  logic [ADDR_W-1:0]            res_addr,
   input  logic [DATA_W-1:0]            res_data,
   input  logic                         flush,
   input  logic                         rd_req,
   output logic                         RegWrite,
   output logic [ADDR_W-1:0]            A3,
   output logic [DATA_W-1:0]            WD3,
   input  logic [ADDR_W-1:0]            fwd_a1,
   output logic                         fwd_hit1,
   output logic [DATA_W-1:0]            fwd_data1,
   input  logic [ADDR_W-1:0]            fwd_a2,
   output logic                         fwd_hit2,
   output logic [DATA_W-1:0]            fwd_data2,
   output logic [$clog2(DEPTH+1)-1:0]   pending
);

   import regfile_pkg::*;

   localparam int CNT_W = $clog2(DEPTH + 1);

   wb_entry_t         in_entry;
   wb_entry_t         fifo_head;
   wb_entry_t         fifo_ent [DEPTH];
   logic [DEPTH-1:0]  fifo_ent_vld;
   logic              fifo_full;
   logic              fifo_empty;
   logic [CNT_W-1:0]  fifo_count;
   logic              accept;
   logic              push;
   logic              pop;

   logic              reg_write_q, reg_write_d;
   logic [ADDR_W-1:0] a3_q, a3_d;
   logic [DATA_W-1:0] wd3_q, wd3_d;

   assign in_entry.addr = res_addr;
   assign in_entry.data = res_data;

   // An accepted $zero write is consumed but never queued; a flush drops the same-cycle accept
   assign res_ready = ~fifo_full;
   assign accept    = res_valid & res_ready;
   assign push      = accept & ~is_zero_reg(res_addr) & ~flush;
   assign pop       = ~fifo_empty & ~rd_req & ~flush;

   wb_fifo #(
      .DEPTH (DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop),
      .flush    (flush),
      .wr_entry (in_entry),
      .head     (fifo_head),
      .full     (fifo_full),
      .empty    (fifo_empty),
      .count    (fifo_count),
      .ent      (fifo_ent),
      .ent_vld  (fifo_ent_vld)
   );

   // Port register: present the head when draining, otherwise hold address/data with RegWrite low
   always_comb begin
      reg_write_d = pop;
      a3_d        = a3_q;
      wd3_d       = wd3_q;
      if (pop) begin
         a3_d  = fifo_head.addr;
         wd3_d = fifo_head.data;
      end
   end

   // Write-port flops
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_write_q <= 1'b0;
         a3_q        <= '0;
         wd3_q       <= '0;
      end else begin
         reg_write_q <= reg_write_d;
         a3_q        <= a3_d;
         wd3_q       <= wd3_d;
      end
   end

   assign RegWrite = reg_write_q;
   assign A3       = a3_q;
   assign WD3      = wd3_q;
   assign pending  = fifo_count;

   // Bypass: the presented entry is oldest, then queue oldest->youngest, so the last match wins
   always_comb begin
      fwd_hit1  = 1'b0;
      fwd_data1 = '0;
      fwd_hit2  = 1'b0;
      fwd_data2 = '0;
      if (reg_write_q && a3_q == fwd_a1) begin
         fwd_hit1  = 1'b1;
         fwd_data1 = wd3_q;
      end
      if (reg_write_q && a3_q == fwd_a2) begin
         fwd_hit2  = 1'b1;
         fwd_data2 = wd3_q;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (fifo_ent_vld[i] && fifo_ent[i].addr == fwd_a1) begin
            fwd_hit1  = 1'b1;
            fwd_data1 = fifo_ent[i].data;
         end
         if (fifo_ent_vld[i] && fifo_ent[i].addr == fwd_a2) begin
            fwd_hit2  = 1'b1;
            fwd_data2 = fifo_ent[i].data;
         end
      end
      if (is_zero_reg(fwd_a1)) begin
         fwd_hit1  = 1'b0;
         fwd_data1 = '0;
      end
      if (is_zero_reg(fwd_a2)) begin
         fwd_hit2  = 1'b0;
         fwd_data2 = '0;
      end
   end

endmodule
